// File: rtl/clk_src_switch_ctrl.sv
// clk_src_switch_ctrl
//
// Generates the select for the glitch-free global clock mux. Runs on the
// always-present internal clock and qualifies the external clock by counting
// edges of a heartbeat toggle from that domain over fixed windows. A settle
// hold-off follows every select change.
//
// Ports:
//   clk        internal free-running clock
//   rst        synchronous active-high reset
//   ext_tick   asynchronous heartbeat toggle from the external domain
//   auto_en    switch to the external clock automatically once qualified
//   force_int  force internal clock (highest priority)
//   force_ext  force external clock (ignored while force_int is high)
//   clk_sel    mux select, 0 = internal, 1 = external
//   switching  high during the settle hold-off
//   ext_good   external source qualified
//   ext_lost   one-cycle pulse on a bad window while running external, unforced
//   edge_count edge count of the last completed window
module clk_src_switch_ctrl #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned MIN_EDGES     = 100,
    parameter int unsigned MAX_EDGES     = 140,
    parameter int unsigned GOOD_WINDOWS  = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_tick,
    input  logic             auto_en,
    input  logic             force_int,
    input  logic             force_ext,
    output logic             clk_sel,
    output logic             switching,
    output logic             ext_good,
    output logic             ext_lost,
    output logic [CNT_W-1:0] edge_count
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned GC_W  = $clog2(GOOD_WINDOWS + 1);

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_L     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_L     = CNT_W'(MAX_EDGES);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [GC_W-1:0]  GOOD_FULL = GC_W'(GOOD_WINDOWS);

    typedef enum logic [1:0] {
        StInt,
        StHoldExt,
        StExt,
        StHoldInt
    } state_e;

    // Heartbeat synchronizer: two flops for metastability, third for edge detect.
    logic tick_meta_q, tick_sync_q, tick_dly_q;
    logic edge_det;

    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic [GC_W-1:0]  good_cnt_q;

    logic [CNT_W-1:0] edge_total;
    logic             win_last;
    logic             window_good;
    logic [GC_W-1:0]  good_cnt_d;
    logic             target;

    state_e           state_q;
    logic [SET_W-1:0] settle_q;

    assign edge_det = tick_sync_q ^ tick_dly_q;
    assign win_last = (win_cnt_q == WIN_LAST);

    always_comb begin
        // Count including this cycle's edge, saturating at all-ones.
        edge_total = edge_cnt_q;
        if (edge_det && (edge_cnt_q != '1)) begin
            edge_total = edge_cnt_q + 1'b1;
        end

        window_good = (edge_total >= MIN_L) && (edge_total <= MAX_L);

        good_cnt_d = '0;
        if (window_good) begin
            good_cnt_d = (good_cnt_q == GOOD_FULL) ? GOOD_FULL : good_cnt_q + 1'b1;
        end

        target = 1'b0;
        if (force_int) begin
            target = 1'b0;
        end else if (force_ext) begin
            target = 1'b1;
        end else if (auto_en) begin
            target = ext_good;
        end
    end

    // Measurement: runs in every FSM state, independent of forcing.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_meta_q <= 1'b0;
            tick_sync_q <= 1'b0;
            tick_dly_q  <= 1'b0;
            win_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            good_cnt_q  <= '0;
            edge_count  <= '0;
            ext_good    <= 1'b0;
            ext_lost    <= 1'b0;
        end else begin
            tick_meta_q <= ext_tick;
            tick_sync_q <= tick_meta_q;
            tick_dly_q  <= tick_sync_q;
            if (win_last) begin
                win_cnt_q  <= '0;
                edge_cnt_q <= '0;
                edge_count <= edge_total;
                good_cnt_q <= good_cnt_d;
                ext_good   <= (good_cnt_d == GOOD_FULL);
                ext_lost   <= !window_good && clk_sel && !force_ext;
            end else begin
                win_cnt_q  <= win_cnt_q + 1'b1;
                edge_cnt_q <= edge_total;
                ext_lost   <= 1'b0;
            end
        end
    end

    // Select FSM. Hold states ignore the target until settle_q reaches its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StInt;
            settle_q  <= '0;
            clk_sel   <= 1'b0;
            switching <= 1'b0;
        end else begin
            case (state_q)
                StInt: begin
                    if (target) begin
                        state_q   <= StHoldExt;
                        settle_q  <= '0;
                        clk_sel   <= 1'b1;
                        switching <= 1'b1;
                    end
                end
                StHoldExt: begin
                    if (settle_q == SET_LAST) begin
                        state_q   <= StExt;
                        switching <= 1'b0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StExt: begin
                    if (!target) begin
                        state_q   <= StHoldInt;
                        settle_q  <= '0;
                        clk_sel   <= 1'b0;
                        switching <= 1'b1;
                    end
                end
                StHoldInt: begin
                    if (settle_q == SET_LAST) begin
                        state_q   <= StInt;
                        switching <= 1'b0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= StInt;
                    settle_q  <= '0;
                    clk_sel   <= 1'b0;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_src_switch_ctrl.sv
// tb_clk_src_switch_ctrl
//
// Bench for clk_src_switch_ctrl with small window/settle parameters. A
// reference model predicts every output each cycle from window-level edge
// counts and a hold-off countdown; table segments and hand sequences add
// fixed expectations for the scenarios of interest.
module tb_clk_src_switch_ctrl;

    localparam int W    = 100;
    localparam int MINE = 20;
    localparam int MAXE = 30;
    localparam int GW   = 2;
    localparam int ST   = 8;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ext_tick = 1'b0;
    logic          auto_en = 1'b0;
    logic          force_int = 1'b0;
    logic          force_ext = 1'b0;
    logic          clk_sel;
    logic          switching;
    logic          ext_good;
    logic          ext_lost;
    logic [CW-1:0] edge_count;

    clk_src_switch_ctrl #(
        .WINDOW_CYCLES(W),
        .MIN_EDGES    (MINE),
        .MAX_EDGES    (MAXE),
        .GOOD_WINDOWS (GW),
        .SETTLE_CYCLES(ST),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_tick  (ext_tick),
        .auto_en   (auto_en),
        .force_int (force_int),
        .force_ext (force_ext),
        .clk_sel   (clk_sel),
        .switching (switching),
        .ext_good  (ext_good),
        .ext_lost  (ext_lost),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int   m_k;          // index of the next non-reset clock edge
    int   m_win_edges;  // edges seen so far in the current window
    int   m_run;        // consecutive good windows, capped at GW
    int   m_hold;       // remaining hold-off cycles
    int   m_ec;
    logic m_sel, m_sw, m_good, m_lost;
    logic m_hist[$];    // last three sampled tick values, oldest first

    // Bench tick generator: toggles every 'half' cycles when nonzero.
    int half = 0;
    int pc = 0;

    task automatic model_reset();
        m_k = 0; m_win_edges = 0; m_run = 0; m_hold = 0; m_ec = 0;
        m_sel = 1'b0; m_sw = 1'b0; m_good = 1'b0; m_lost = 1'b0;
        m_hist = '{1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_edge(input logic r, input logic ae, input logic fi,
                              input logic fe, input logic tk);
        logic tgt, old_sel, e, good;
        if (r) begin
            model_reset();
            return;
        end
        tgt = fi ? 1'b0 : (fe ? 1'b1 : (ae ? m_good : 1'b0));
        old_sel = m_sel;
        // A tick transition is counted two edges after it is first sampled.
        e = (m_hist[1] != m_hist[0]);
        if (e) m_win_edges++;
        m_lost = 1'b0;
        if (m_k % W == W - 1) begin
            good = (m_win_edges >= MINE) && (m_win_edges <= MAXE);
            m_ec = m_win_edges;
            m_run = good ? ((m_run < GW) ? m_run + 1 : GW) : 0;
            m_good = (m_run == GW);
            m_lost = !good && old_sel && !fe;
            m_win_edges = 0;
        end
        if (m_hold > 0) begin
            m_hold--;
        end else if (tgt != m_sel) begin
            m_sel = tgt;
            m_hold = ST;
        end
        m_sw = (m_hold > 0);
        m_hist.push_back(tk);
        void'(m_hist.pop_front());
        m_k++;
    endtask

    task automatic step();
        logic r, ae, fi, fe, tk;
        logic [CW-1:0] ec_exp;
        r = rst; ae = auto_en; fi = force_int; fe = force_ext; tk = ext_tick;
        @(posedge clk);
        model_edge(r, ae, fi, fe, tk);
        #1;
        ec_exp = m_ec[CW-1:0];
        checks++;
        if ({clk_sel, switching, ext_good, ext_lost, edge_count} !==
            {m_sel, m_sw, m_good, m_lost, ec_exp}) begin
            errors++;
            $display("FAIL cycle k=%0d: got sel=%b sw=%b good=%b lost=%b ec=%0d, want sel=%b sw=%b good=%b lost=%b ec=%0d",
                     m_k, clk_sel, switching, ext_good, ext_lost, edge_count,
                     m_sel, m_sw, m_good, m_lost, ec_exp);
        end
        if (half > 0) begin
            pc++;
            if (pc >= half) begin
                ext_tick = ~ext_tick;
                pc = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst, auto_en, force_int, force_ext;
        int   half, n;
        logic e_sel, e_sw, e_good, e_lost;
        int   ec_lo, ec_hi;
    } seg_t;

    seg_t segs[14];

    task automatic check_seg(input int idx, input seg_t s);
        checks++;
        if ($isunknown({clk_sel, switching, ext_good, ext_lost, edge_count}) ||
            clk_sel != s.e_sel || switching != s.e_sw || ext_good != s.e_good ||
            ext_lost != s.e_lost || int'(edge_count) < s.ec_lo ||
            int'(edge_count) > s.ec_hi) begin
            errors++;
            $display("FAIL seg%0d: got sel=%b sw=%b good=%b lost=%b ec=%0d, want sel=%b sw=%b good=%b lost=%b ec=%0d..%0d",
                     idx, clk_sel, switching, ext_good, ext_lost, edge_count,
                     s.e_sel, s.e_sw, s.e_good, s.e_lost, s.ec_lo, s.ec_hi);
        end
    endtask

    // Emits exactly n tick transitions early in one window, then checks the count.
    task automatic window_with_edges(input int n, input logic exp_good);
        int guard = 0;
        while ((m_k % W) != 0 && guard < 2 * W) begin
            step();
            guard++;
        end
        for (int p = 0; p < W; p++) begin
            if (p >= 2 && (p - 2) % 3 == 0 && (p - 2) / 3 < n) ext_tick = ~ext_tick;
            step();
        end
        chk($sformatf("window%0d_ec", n), int'(edge_count), n);
        chk($sformatf("window%0d_good", n), int'(ext_good), int'(exp_good));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rate;
        model_reset();

        //        rst  ae   fi   fe  half  n   sel  sw  good lost  lo  hi
        segs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 3,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        segs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 99,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        segs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 1,   1'b0, 1'b0, 1'b0, 1'b0, 23, 26};
        segs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 100, 1'b0, 1'b0, 1'b1, 1'b0, 25, 25};
        segs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 1,   1'b1, 1'b1, 1'b1, 1'b0, 25, 25};
        segs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 7,   1'b1, 1'b1, 1'b1, 1'b0, 25, 25};
        segs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 1,   1'b1, 1'b0, 1'b1, 1'b0, 25, 25};
        segs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 91,  1'b1, 1'b0, 1'b0, 1'b1, 0, 6};
        segs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1,   1'b0, 1'b1, 1'b0, 1'b0, 0, 6};
        segs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 7,   1'b0, 1'b1, 1'b0, 1'b0, 0, 6};
        segs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1,   1'b0, 1'b0, 1'b0, 1'b0, 0, 6};
        segs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 91,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        segs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 100, 1'b0, 1'b0, 1'b0, 1'b0, 44, 50};
        segs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 100, 1'b0, 1'b0, 1'b0, 1'b0, 50, 50};

        for (int i = 0; i < 14; i++) begin
            rst = segs[i].rst;
            auto_en = segs[i].auto_en;
            force_int = segs[i].force_int;
            force_ext = segs[i].force_ext;
            if (segs[i].half != half) begin
                half = segs[i].half;
                pc = 0;
            end
            run(segs[i].n);
            check_seg(i, segs[i]);
        end

        // Window boundaries: 20 and 30 are good, 19 and 31 are bad.
        auto_en = 1'b0;
        half = 0;
        pc = 0;
        run(W);
        window_with_edges(20, 1'b0);
        window_with_edges(30, 1'b1);
        window_with_edges(31, 1'b0);
        window_with_edges(20, 1'b0);
        window_with_edges(19, 1'b0);
        window_with_edges(20, 1'b0);

        // Forced external, then force_int arriving during the hold-off.
        force_ext = 1'b1;
        step();
        chk("force_ext_sel", int'(clk_sel), 1);
        chk("force_ext_sw", int'(switching), 1);
        step();
        force_int = 1'b1;
        run(6);
        chk("hold_ignores_force_int", int'(clk_sel), 1);
        step();
        chk("hold_end_sel", int'(clk_sel), 1);
        chk("hold_end_sw", int'(switching), 0);
        step();
        chk("force_int_drop", int'(clk_sel), 0);
        chk("force_int_drop_sw", int'(switching), 1);
        run(8);
        chk("both_forces_sel", int'(clk_sel), 0);
        chk("both_forces_sw", int'(switching), 0);
        force_int = 1'b0;
        force_ext = 1'b0;

        // Reset in the third hold-off cycle clears select and qualification.
        rst = 1'b1;
        step();
        rst = 1'b0;
        auto_en = 1'b1;
        half = 4;
        pc = 0;
        run(2 * W);
        chk("requal_good", int'(ext_good), 1);
        run(3);
        chk("mid_hold_sel", int'(clk_sel), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_hold_sel", int'(clk_sel), 0);
        chk("rst_mid_hold_sw", int'(switching), 0);
        chk("rst_mid_hold_good", int'(ext_good), 0);
        run(W);
        chk("after_rst_one_window", int'(ext_good), 0);
        run(W);
        chk("after_rst_two_windows", int'(ext_good), 1);
        step();
        chk("after_rst_sel", int'(clk_sel), 1);

        // Random traffic: per-window tick rate near the limits, sparse control changes.
        half = 0;
        rate = 25;
        for (int c = 0; c < 3000; c++) begin
            if (m_k % W == 0) rate = 15 + int'($urandom_range(20));
            if (int'($urandom_range(99)) < rate) ext_tick = ~ext_tick;
            if ($urandom_range(49) == 0) auto_en = $urandom_range(1) != 0;
            if ($urandom_range(79) == 0) force_int = ~force_int;
            if ($urandom_range(59) == 0) force_ext = ~force_ext;
            rst = ($urandom_range(1499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_src_switch_ctrl.md
# clk_src_switch_ctrl

Clock-source selection controller that generates the select for the design's glitch-free global clock mux. It runs on the always-present internal clock and qualifies the external/alternate clock through a divided toggle ("heartbeat") from that domain. It drives `clk_sel` to the mux and returns to the internal clock if the external source goes out of range. It enforces a settle hold-off after every select change so the mux never sees back-to-back toggles.

## Interface
Parameters:
- `WINDOW_CYCLES`, 1024: length of one measurement window in `clk` cycles.
- `MIN_EDGES`, 100: minimum heartbeat edges per window for a good window (inclusive).
- `MAX_EDGES`, 140: maximum heartbeat edges per window for a good window (inclusive).
- `GOOD_WINDOWS`, 4: consecutive good windows needed before `ext_good` is asserted.
- `SETTLE_CYCLES`, 64: hold-off after a select change; must be ≥1.
- `CNT_W`, 16: width of the edge counter and the window counter; must hold `WINDOW_CYCLES`.

Ports:
- `clk`, input, 1: internal free-running clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ext_tick`, input, 1: asynchronous heartbeat toggle from the external clock domain.
- `auto_en`, input, 1: enable automatic switching to the external clock when it is qualified.
- `force_int`, input, 1: force the internal clock; highest priority.
- `force_ext`, input, 1: force the external clock; ignored while `force_int` is high.
- `clk_sel`, output, 1: mux select; 0 = internal, 1 = external.
- `switching`, output, 1: high during the settle hold-off.
- `ext_good`, output, 1: external source qualified.
- `ext_lost`, output, 1: one-cycle pulse when a bad window is seen while `clk_sel`=1 and `force_ext`=0.
- `edge_count`, output, CNT_W: edge count of the last completed window.

## Operation
- **Synchronizer.** `ext_tick` passes through two flops, then a third flop for edge detection. Each transition of the synchronized signal, rising or falling, counts as one edge.
- **Window counter.**
  - Counts 0..`WINDOW_CYCLES`-1, then wraps.
  - On the last cycle, the edge count, including any edge in that cycle, is latched into `edge_count`.
  - The edge counter restarts at 0, or at 1 if an edge lands on the first cycle of the new window.
  - The edge counter saturates at all-ones.
- **Window result.** good = `MIN_EDGES` ≤ count ≤ `MAX_EDGES`.
  - `good_cnt` increments on a good window and saturates at `GOOD_WINDOWS`.
  - A bad window clears `good_cnt` to 0.
  - `ext_good` = (`good_cnt` == `GOOD_WINDOWS`).
- **Target select.**
  - 0 if `force_int` is high.
  - Otherwise 1 if `force_ext` is high.
  - Otherwise `ext_good` if `auto_en` is high.
  - Otherwise 0.
- **FSM states.**
  - INT: `clk_sel`=0. Target 1 → HOLD_EXT.
  - HOLD_EXT: `clk_sel`=1, `switching`=1. Settle counter runs `SETTLE_CYCLES` cycles, then → EXT. Target changes are ignored until the hold-off ends.
  - EXT: `clk_sel`=1. Target 0 → HOLD_INT.
  - HOLD_INT: `clk_sel`=0, `switching`=1. After `SETTLE_CYCLES` → INT.
- **Hold-off.** A select change is never followed by another within `SETTLE_CYCLES` cycles. A target still differing at the end of a hold transitions on the next cycle.
- **Measurement.** Measurement runs continuously in every state and is unaffected by forcing.

## Timing
- **Reset values.**
  - State INT; `clk_sel`=0, `switching`=0, `ext_good`=0, `ext_lost`=0, `edge_count`=0.
  - All counters 0; synchronizer flops 0.
  - Reset mid-hold or in EXT returns `clk_sel` to 0 on the cycle after `rst` is sampled.
- **Registered outputs.** All outputs are registered.
- **Input to `clk_sel`.** A target change sampled in INT/EXT on cycle N changes `clk_sel` and raises `switching` at N+1.
- **Hold duration.** `switching` stays high for exactly `SETTLE_CYCLES` cycles.
- **Heartbeat latency.** An `ext_tick` transition reaches the edge detect 3 cycles later.
- **Window results.**
  - `edge_count`, `ext_good` and `ext_lost` update the cycle after the window's last cycle.
  - A bad window drops `ext_good` in that same update.
  - In auto mode, `clk_sel` then falls one cycle later, unless a hold-off is active.
- **Simultaneous forces.** `force_int` and `force_ext` both high behaves as `force_int`.

## Test plan
Parameter overrides for all scenarios: `WINDOW_CYCLES`=100, `MIN_EDGES`=20, `MAX_EDGES`=30, `GOOD_WINDOWS`=2, `SETTLE_CYCLES`=8.

- **Reset defaults.** Hold `rst` 3 cycles with the tick toggling → all outputs 0. First `edge_count` appears 100 cycles after reset release.
- **Auto qualify.** `auto_en`=1, tick toggling every 4 cycles (25 edges/window) → `edge_count`=25. `ext_good` rises after the 2nd window. `clk_sel` rises 1 cycle later. `switching` is high 8 cycles, then low.
- **Loss fallback.** In EXT, stop the tick → next window gives `edge_count`=0 (or the partial count), a one-cycle `ext_lost` pulse, and `ext_good`=0. `clk_sel` goes 0 the next cycle, then 8 hold-off cycles.
- **Out of range.** Tick every 2 cycles (50 edges/window) → `edge_count`=50, `ext_good` stays 0, `clk_sel` stays 0. Boundaries: 20 and 30 edges count as good; 19 and 31 count as bad.
- **Overrides and hold-off.**
  - `force_ext`=1 with no tick → `clk_sel`=1 after 1 cycle.
  - Pulse `force_int` during HOLD_EXT → `clk_sel` stays 1 until the 8-cycle hold-off ends, then drops the next cycle.
  - `force_int` and `force_ext` both high → `clk_sel`=0.
- **Reset mid-hold.** Assert `rst` in HOLD_EXT cycle 3 → `clk_sel`=0 and `switching`=0 the next cycle, and `good_cnt` is cleared: `ext_good` must take 2 new windows to reassert.
